// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU front end.
// Fetch FSM state encoding plus the reset and halt addresses.
package mips_cpu_pkg;

   localparam int          INSTR_W      = 32;
   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

   typedef enum logic [1:0] {
      START = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   function automatic logic misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mips_cpu_fetch_if.sv
// Avalon-style instruction read bus between the fetch stage (master) and memory (slave).
interface mips_cpu_fetch_if;
   import mips_cpu_pkg::*;

   logic [31:0]        instr_address;
   logic               instr_read;
   logic               instr_waitrequest;
   logic [INSTR_W-1:0] instr_readdata;

   modport master (
      output instr_address,
      output instr_read,
      input  instr_waitrequest,
      input  instr_readdata
   );

   modport slave (
      input  instr_address,
      input  instr_read,
      output instr_waitrequest,
      output instr_readdata
   );

endinterface

// File: rtl/mips_cpu_next_pc.sv
// Next fetch address for the instruction being accepted: redirect target select,
// branch-delay-slot bookkeeping via a pending target, and halt/fault detection.
module mips_cpu_next_pc
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] HALT_ADDR = mips_cpu_pkg::HALT_ADDR
) (
   input  logic [31:0] pc_out,
   input  logic [25:0] instr_index,
   input  logic        pcsrc,
   input  logic        jump,
   input  logic        jump1,
   input  logic [31:0] branch_target,
   input  logic [31:0] jr_target,
   input  logic        pend_vld,
   input  logic [31:0] pend_pc,
   output logic [31:0] next_pc,
   output logic        pend_vld_nxt,
   output logic [31:0] pend_pc_nxt,
   output logic        fault,
   output logic        halt
);

   logic [31:0] seq_pc;
   logic [31:0] tgt;
   logic        redir;

   always_comb begin
      seq_pc = pc_out + 32'd4;
      redir  = jump1 | jump | pcsrc;

      if (jump1)     tgt = jr_target;
      else if (jump) tgt = {seq_pc[31:28], instr_index, 2'b00};
      else           tgt = branch_target;

      next_pc      = seq_pc;
      pend_vld_nxt = 1'b0;
      pend_pc_nxt  = pend_pc;
      fault        = 1'b0;

      // A delay-slot instruction is being accepted: the stored target wins and
      // any redirect flagged alongside it is dropped.
      if (pend_vld) begin
         next_pc = pend_pc;
         fault   = misaligned(pend_pc);
      end else if (redir) begin
         pend_vld_nxt = 1'b1;
         pend_pc_nxt  = tgt;
      end

      halt = !fault && (next_pc == HALT_ADDR);
   end

endmodule

// File: rtl/mips_cpu_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction bus, and hands the
// captured word to the decoder over a valid/ready handshake.
module mips_cpu_fetch
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
   parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
   input  logic                clk,
   input  logic                reset,
   mips_cpu_fetch_if.master    ibus,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [31:0]         pc_out,
   output logic [31:0]         pc_plus8,
   input  logic                pcsrc,
   input  logic                jump,
   input  logic                jump1,
   input  logic [31:0]         branch_target,
   input  logic [31:0]         jr_target,
   output logic                active,
   output logic                fault
);

   fetch_state_t       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [31:0]        pc_out_q, pc_out_d;
   logic               instr_valid_q, instr_valid_d;
   logic               active_q, active_d;
   logic               fault_q, fault_d;
   logic               pend_vld_q, pend_vld_d;
   logic [31:0]        pend_pc_q, pend_pc_d;

   logic [31:0] np_pc;
   logic        np_pend_vld;
   logic [31:0] np_pend_pc;
   logic        np_fault;
   logic        np_halt;
   logic        accept;

   mips_cpu_next_pc #(.HALT_ADDR(HALT_ADDR)) u_next_pc (
      .pc_out        (pc_out_q),
      .instr_index   (instr_q[25:0]),
      .pcsrc         (pcsrc),
      .jump          (jump),
      .jump1         (jump1),
      .branch_target (branch_target),
      .jr_target     (jr_target),
      .pend_vld      (pend_vld_q),
      .pend_pc       (pend_pc_q),
      .next_pc       (np_pc),
      .pend_vld_nxt  (np_pend_vld),
      .pend_pc_nxt   (np_pend_pc),
      .fault         (np_fault),
      .halt          (np_halt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= START;
         pc_q          <= RESET_VECTOR;
         instr_q       <= '0;
         pc_out_q      <= '0;
         instr_valid_q <= 1'b0;
         active_q      <= 1'b1;
         fault_q       <= 1'b0;
         pend_vld_q    <= 1'b0;
         pend_pc_q     <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         pc_out_q      <= pc_out_d;
         instr_valid_q <= instr_valid_d;
         active_q      <= active_d;
         fault_q       <= fault_d;
         pend_vld_q    <= pend_vld_d;
         pend_pc_q     <= pend_pc_d;
      end
   end

   assign accept = instr_valid_q && instr_ready;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      pc_out_d      = pc_out_q;
      instr_valid_d = instr_valid_q;
      active_d      = active_q;
      fault_d       = fault_q;
      pend_vld_d    = pend_vld_q;
      pend_pc_d     = pend_pc_q;

      case (state_q)
         START: state_d = FETCH;
         FETCH: begin
            if (!ibus.instr_waitrequest) begin
               instr_d       = ibus.instr_readdata;
               pc_out_d      = pc_q;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (accept) begin
               instr_valid_d = 1'b0;
               pc_d          = np_pc;
               pend_vld_d    = np_pend_vld;
               pend_pc_d     = np_pend_pc;
               if (np_fault) begin
                  fault_d  = 1'b1;
                  active_d = 1'b0;
                  state_d  = HALT;
               end else if (np_halt) begin
                  active_d = 1'b0;
                  state_d  = HALT;
               end else begin
                  state_d  = FETCH;
               end
            end
         end
         HALT: begin
            instr_valid_d = 1'b0;
            pend_vld_d    = 1'b0;
         end
         default: state_d = START;
      endcase
   end

   // Read strobe decodes straight from the state so reset kills it without waiting for a clock.
   assign ibus.instr_address = pc_q;
   assign ibus.instr_read    = (state_q == FETCH);

   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc_out      = pc_out_q;
   assign pc_plus8    = pc_out_q + 32'd8;
   assign active      = active_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Self-checking bench for mips_cpu_fetch: memory responder with a fetch-address
// scoreboard, a table of decoder accepts, and hand-written reset/stall/fault sequences.
module tb_mips_cpu_fetch;
   import mips_cpu_pkg::*;

   typedef struct {
      logic [31:0] pc;
      int          hold;
      logic        pcsrc;
      logic        jump;
      logic        jump1;
      logic [31:0] bt;
      logic [31:0] jt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr, pc_out, pc_plus8, branch_target, jr_target;
   logic        instr_valid, instr_ready, pcsrc, jump, jump1, active, fault;

   int checks = 0;
   int errors = 0;
   int stall_req = 0;
   int stall_used = 0;
   logic [31:0] exp_fetch[$];
   vec_t tbl[12];

   mips_cpu_fetch_if bus();

   mips_cpu_fetch dut (
      .clk           (clk),
      .reset         (rst),
      .ibus          (bus),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .pc_out        (pc_out),
      .pc_plus8      (pc_plus8),
      .pcsrc         (pcsrc),
      .jump          (jump),
      .jump1         (jump1),
      .branch_target (branch_target),
      .jr_target     (jr_target),
      .active        (active),
      .fault         (fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return ~a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory slave: drives data/stall for the coming edge and scoreboards completed reads.
   always @(negedge clk) begin : responder
      logic [31:0] e;
      if (rst) stall_used = 0;
      bus.instr_readdata = mem(bus.instr_address);
      if (bus.instr_read && stall_used < stall_req) begin
         bus.instr_waitrequest = 1'b1;
         stall_used++;
      end else begin
         bus.instr_waitrequest = 1'b0;
         if (bus.instr_read && !rst) begin
            if (exp_fetch.size() == 0) chk("unexpected_read", bus.instr_address, 32'hDEAD_DEAD);
            else begin
               e = exp_fetch.pop_front();
               chk("fetch_addr", bus.instr_address, e);
            end
         end
      end
   end

   task automatic accept(input vec_t v);
      int   n;
      logic ok;
      n = 0;
      while (!instr_valid && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
      chk("pc_out", pc_out, v.pc);
      chk("instr", instr, mem(v.pc));
      chk("pc_plus8", pc_plus8, v.pc + 32'd8);
      if (v.hold > 0) begin
         ok = 1'b1;
         repeat (v.hold) begin
            @(negedge clk); #1;
            if (bus.instr_read || !instr_valid || pc_out !== v.pc || instr !== mem(v.pc)) ok = 1'b0;
         end
         chk("hold_stable", {31'd0, ok}, 32'd1);
      end
      instr_ready   = 1'b1;
      pcsrc         = v.pcsrc;
      jump          = v.jump;
      jump1         = v.jump1;
      branch_target = v.bt;
      jr_target     = v.jt;
      @(negedge clk);
      instr_ready = 1'b0;
      pcsrc = 1'b0; jump = 1'b0; jump1 = 1'b0;
      #1;
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input int hold, input logic ps, input logic j,
                               input logic j1, input logic [31:0] bt, input logic [31:0] jt);
      vec_t v;
      v.pc = pc; v.hold = hold; v.pcsrc = ps; v.jump = j; v.jump1 = j1; v.bt = bt; v.jt = jt;
      return v;
   endfunction

   initial begin
      int n;
      tbl[0]  = mk(32'hBFC0_0000, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(32'hBFC0_0004, 5, 0, 0, 0, 0, 0);
      tbl[2]  = mk(32'hBFC0_0008, 0, 0, 1, 0, 0, 0);
      tbl[3]  = mk(32'hBFC0_000C, 0, 0, 0, 0, 0, 0);
      tbl[4]  = mk(32'hB0FF_FFDC, 0, 0, 0, 1, 0, 32'hBFC0_0010);
      tbl[5]  = mk(32'hB0FF_FFE0, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(32'hBFC0_0010, 0, 1, 0, 0, 32'hBFC0_0100, 0);
      tbl[7]  = mk(32'hBFC0_0014, 0, 0, 0, 1, 0, 32'h0000_0000);
      tbl[8]  = mk(32'hBFC0_0100, 0, 0, 0, 1, 0, 32'hBFC0_0020);
      tbl[9]  = mk(32'hBFC0_0104, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(32'hBFC0_0020, 0, 0, 0, 1, 0, 32'h0000_0000);
      tbl[11] = mk(32'hBFC0_0024, 0, 0, 0, 0, 0, 0);

      rst = 1'b1; instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0; jump1 = 1'b0;
      branch_target = '0; jr_target = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_read", {31'd0, bus.instr_read}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd1);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_instr", instr, 32'd0);

      // Run 1: straight-line, hold, J, jr, branch with ignored redirect in slot, halt at 0
      foreach (tbl[i]) exp_fetch.push_back(tbl[i].pc);
      @(negedge clk); rst = 1'b0; #1;
      chk("start_read", {31'd0, bus.instr_read}, 32'd0);
      @(negedge clk); #1;
      chk("first_read", {31'd0, bus.instr_read}, 32'd1);
      chk("first_addr", bus.instr_address, 32'hBFC0_0000);
      for (int i = 0; i < 12; i++) accept(tbl[i]);
      chk("halt_active", {31'd0, active}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      repeat (4) @(negedge clk);
      #1;
      chk("halt_read", {31'd0, bus.instr_read}, 32'd0);
      chk("halt_fault", {31'd0, fault}, 32'd0);
      chk("run1_sb_empty", exp_fetch.size(), 32'd0);

      // Run 2: three stall cycles on first read, then misaligned jr target -> fault
      rst = 1'b1; stall_req = 3;
      @(negedge clk); #1;
      exp_fetch.push_back(32'hBFC0_0000);
      @(negedge clk); rst = 1'b0;
      n = 0;
      repeat (4) begin
         @(negedge clk); #1;
         if (bus.instr_read && bus.instr_address == 32'hBFC0_0000 && !instr_valid) n++;
      end
      chk("stall_cycles", n, 32'd4);
      @(negedge clk); #1;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_read_off", {31'd0, bus.instr_read}, 32'd0);
      exp_fetch.push_back(32'hBFC0_0004);
      accept(mk(32'hBFC0_0000, 0, 0, 0, 1, 0, 32'hBFC0_0102));
      chk("fault_pre", {31'd0, fault}, 32'd0);
      accept(mk(32'hBFC0_0004, 0, 0, 0, 0, 0, 0));
      chk("fault_set", {31'd0, fault}, 32'd1);
      chk("fault_active", {31'd0, active}, 32'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("fault_read", {31'd0, bus.instr_read}, 32'd0);

      // Run 3: reset clears fault; reset asserted mid-read abandons the transaction
      rst = 1'b1; stall_req = 1000;
      @(negedge clk); #1;
      chk("rst_clr_fault", {31'd0, fault}, 32'd0);
      chk("rst_clr_active", {31'd0, active}, 32'd1);
      @(negedge clk); rst = 1'b0;
      n = 0;
      while (!bus.instr_read && n < 10) begin
         @(negedge clk); #1;
         n++;
      end
      @(negedge clk); #2;
      chk("midread_read", {31'd0, bus.instr_read}, 32'd1);
      rst = 1'b1; #1;
      chk("async_read_drop", {31'd0, bus.instr_read}, 32'd0);
      chk("async_fault", {31'd0, fault}, 32'd0);
      stall_req = 0;
      exp_fetch.push_back(32'hBFC0_0000);
      @(negedge clk); rst = 1'b0; #1;
      exp_fetch.push_back(32'hBFC0_0004);
      accept(mk(32'hBFC0_0000, 0, 0, 0, 0, 0, 0));
      exp_fetch.push_back(32'hBFC0_0008);
      accept(mk(32'hBFC0_0004, 0, 0, 0, 0, 0, 0));
      repeat (3) @(negedge clk);
      #1;
      chk("run3_sb_empty", exp_fetch.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_cpu_fetch.md
Name: mips_cpu_fetch

Overview:
Instruction-fetch stage directly upstream of the controller/decoder. Holds the PC and issues Avalon-style reads on the instruction bus (waitrequest-stalled). Presents the captured instruction word with a valid/ready handshake; the decoder consumes op/funct/dest from it. Takes the controller's pcsrc/jump/jump1 back to redirect the PC, honouring the MIPS branch delay slot, and halts on a fetch from address 0.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC loaded on reset
HALT_ADDR, 32'h00000000, fetch address that stops the CPU

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
instr_address  out  32  instruction bus address (= pc)
instr_read  out  1  instruction bus read strobe
instr_waitrequest  in  1  bus stall; read completes in a cycle with read=1, waitrequest=0
instr_readdata  in  32  read data, valid in the completing cycle
instr  out  32  registered instruction word to decoder
instr_valid  out  1  instr holds an unconsumed instruction
instr_ready  in  1  decoder/datapath accepts instr this cycle
pc_out  out  32  address of the instruction in instr
pc_plus8  out  32  link value (pc_out+8) for jal/jalr
pcsrc  in  1  taken branch for the accepted instruction
jump  in  1  J-type jump for the accepted instruction
jump1  in  1  register jump (jr/jalr) for the accepted instruction
branch_target  in  32  pc_out+4+(sext(imm)<<2)
jr_target  in  32  rs value
active  out  1  high until halt or fault
fault  out  1  misaligned redirect target detected

Behaviour:
- States: START, FETCH, HOLD, HALT. Reset value: START; pc=RESET_VECTOR; instr=0; instr_valid=0; instr_read=0; active=1; fault=0; pending redirect cleared.
- START: one idle cycle after reset release -> FETCH. instr_read=0.
- FETCH: instr_read=1, instr_address=pc. If waitrequest=1, hold address and read unchanged. If waitrequest=0, capture readdata into instr, pc_out<=pc, instr_valid<=1, state -> HOLD. Minimum 2 cycles per instruction.
- HOLD: instr_read=0. Accept = instr_valid && instr_ready. On accept: instr_valid<=0, compute next pc, -> FETCH (or HALT). Without accept, instr/pc_out stay stable indefinitely.
- Redirect sampling, only in the accept cycle, priority jump1 > jump > pcsrc:
  - jump1: target = jr_target.
  - jump: target = {pc_out+4 [31:28], instr[25:0], 2'b00}.
  - pcsrc: target = branch_target.
- Delay slot: on redirect, next fetch is pc_out+4 (delay slot). Target is stored in a pending register, and the fetch after that uses it. Without redirect, next pc = pc_out+4 (32-bit wrap, no flag).
- Redirect asserted while accepting a delay-slot instruction (pending set): ignored; pending target wins.
- Target with bits[1:0]!=0: fault<=1, active<=0, -> HALT after the delay slot is fetched and accepted.
- Halt: when the next fetch address equals HALT_ADDR, go to HALT instead of FETCH. active<=0 in that transition. No reads are issued. The delay slot has already been delivered.
- HALT: absorbing until reset. instr_valid=0, instr_read=0.
- Reset mid-read: instr_read drops asynchronously and the bus transaction is abandoned. Pending redirect and fault are cleared.
- pc_plus8 = pc_out+8, combinational.

Decomposition:
- Shared package mips_cpu_pkg: fetch_state_t enum {START, FETCH, HOLD, HALT}, RESET_VECTOR and HALT_ADDR constants, INSTR_W=32.
- One sub-module is natural: mips_cpu_next_pc, combinational target select plus delay-slot/pending logic, so it can be checked in isolation.

Test Plan:
- Reset, waitrequest=0, ready=1 -> first read at 0xBFC00000 two cycles after reset release; instr=readdata; second read at 0xBFC00004.
- waitrequest held high 3 cycles on first read -> address/read stable 4 cycles; instr_valid rises the cycle after waitrequest=0.
- ready=0 for 5 cycles in HOLD -> instr, pc_out constant, no new reads; then ready=1 -> next fetch pc_out+4.
- Accept beq at 0xBFC00010 with pcsrc=1, branch_target=0xBFC00100 -> fetch order 0xBFC00014, then 0xBFC00100.
- Accept jr with jr_target=0 at 0xBFC00020 -> delay slot 0xBFC00024 fetched and delivered, then active=0, no further reads, state HALT.
- jr_target=0xBFC00102 -> fault=1 after delay slot; assert reset mid-FETCH with waitrequest=1 -> instr_read=0 same cycle, fault=0, restart at 0xBFC00000.
